spi_slave_word: RTL and testbench

- Fully synchronous, oversampled SPI slave; successor to the byte-wide, dual-clock slave.
- All SPI pins are sampled in the system clock domain. Word width, bit order and SPI mode are parametrised.
- Adds a ready/valid TX holding register with underrun reporting, abort detection, and an explicit MISO output-enable for pad-level tristating.
- Sits between the chip SPI pins and the register/command logic.

---
 rtl/spi_slave_word.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave_word.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_word
// Brief    : Oversampled word-wide SPI slave with TX holding register.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_word #(
    parameter int                WORD_W    = 8,
    parameter int                SPI_MODE  = 0,
    parameter bit                LSB_FIRST = 1'b0,
    parameter logic [WORD_W-1:0] IDLE_WORD = '0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [WORD_W-1:0] i_TX_Data,
    input  logic              i_TX_Valid,
    output logic              o_TX_Ready,
    output logic              o_TX_Underrun,
    output logic [WORD_W-1:0] o_RX_Data,
    output logic              o_RX_Valid,
    output logic              o_Abort,
    output logic              o_Busy,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO,
    output logic              o_SPI_MISO_OE
);
    localparam logic                C_CPOL   = ((SPI_MODE >> 1) & 1) == 1;
    localparam logic                C_CPHA   = (SPI_MODE & 1) == 1;
    localparam int                  C_CNT_W  = $clog2(WORD_W);
    localparam logic [C_CNT_W-1:0]  C_LAST   = C_CNT_W'(WORD_W - 1);
    localparam logic [0:0]          C_IDLE   = 1'b0;
    localparam logic [0:0]          C_ACTIVE = 1'b1;

    logic [2:0]        sclk_q;
    logic [1:0]        cs_q;
    logic [1:0]        mosi_q;
    logic [0:0]        state_q, state_d;
    logic              w_active;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic              load_pend_q, load_pend_d;
    logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              ready_q, ready_d;
    logic [WORD_W-1:0] rx_sr_q, rx_sr_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic              rx_done_q, rx_done_d;
    logic              rx_valid_q;
    logic              underrun_q, underrun_d;
    logic              abort_q, abort_d;

    logic              w_lead, w_trail, w_sel, w_sample, w_shift;
    logic              w_cs_fall, w_cs_rise, w_load;
    logic [WORD_W-1:0] w_rx_next, w_tx_adv;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sclk_q <= {3{C_CPOL}};
            cs_q   <= 2'b11;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], i_SPI_Clk};
            cs_q   <= {cs_q[0], i_SPI_CS_n};
            mosi_q <= {mosi_q[0], i_SPI_MOSI};
        end
    end

    // Edge roles are fixed by CPOL/CPHA; only synchronised samples are used.
    assign w_lead    = (sclk_q[1] != C_CPOL) && (sclk_q[2] == C_CPOL);
    assign w_trail   = (sclk_q[1] == C_CPOL) && (sclk_q[2] != C_CPOL);
    assign w_sel     = (state_q == C_ACTIVE) && !cs_q[1];
    assign w_sample  = w_sel && (C_CPHA ? w_trail : w_lead);
    assign w_shift   = w_sel && (C_CPHA ? w_lead : w_trail);
    assign w_cs_fall = (state_q == C_IDLE) && !cs_q[1];
    assign w_cs_rise = (state_q == C_ACTIVE) && cs_q[1];
    assign w_load    = (w_cs_fall && !C_CPHA) || (w_shift && load_pend_q);
    assign w_rx_next = LSB_FIRST ? {mosi_q[1], rx_sr_q[WORD_W-1:1]}
                                 : {rx_sr_q[WORD_W-2:0], mosi_q[1]};
    assign w_tx_adv  = LSB_FIRST ? {1'b0, tx_sr_q[WORD_W-1:1]}
                                 : {tx_sr_q[WORD_W-2:0], 1'b0};

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:   if (!cs_q[1]) state_d = C_ACTIVE;
            C_ACTIVE: if (cs_q[1])  state_d = C_IDLE;
            default:  state_d = C_IDLE;
        endcase
    end

    always_comb begin
        w_active = (state_q == C_ACTIVE);
    end

    always_comb begin
        cnt_d       = cnt_q;
        load_pend_d = load_pend_q;
        tx_sr_d     = tx_sr_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;

        if (w_cs_fall) begin
            cnt_d = '0;
            if (C_CPHA) load_pend_d = 1'b1;
        end
        if (w_cs_rise) begin
            cnt_d       = '0;
            load_pend_d = 1'b0;
            abort_d     = (cnt_q != '0);
        end
        if (w_sample) begin
            rx_sr_d = w_rx_next;
            if (cnt_q == C_LAST) begin
                rx_data_d   = w_rx_next;
                rx_done_d   = 1'b1;
                cnt_d       = '0;
                load_pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (w_shift && !load_pend_q) tx_sr_d = w_tx_adv;
        if (w_load) begin
            load_pend_d = 1'b0;
            if (hold_full_q) begin
                tx_sr_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_sr_d    = IDLE_WORD;
                underrun_d = 1'b1;
            end
        end
        // Ready reflects the pre-load state, so a full register is never overwritten.
        if (i_TX_Valid && ready_q) begin
            hold_d      = i_TX_Data;
            hold_full_d = 1'b1;
        end
    end

    assign ready_d = !hold_full_d;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q       <= '0;
            load_pend_q <= 1'b0;
            tx_sr_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            load_pend_q <= load_pend_d;
            tx_sr_q     <= tx_sr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_valid_q  <= rx_done_q;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
        end
    end

    assign o_TX_Ready    = ready_q;
    assign o_TX_Underrun = underrun_q;
    assign o_RX_Data     = rx_data_q;
    assign o_RX_Valid    = rx_valid_q;
    assign o_Abort       = abort_q;
    assign o_Busy        = w_active;
    assign o_SPI_MISO_OE = w_active;
    assign o_SPI_MISO    = LSB_FIRST ? tx_sr_q[0] : tx_sr_q[WORD_W-1];

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_word.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_word
// Brief    : Directed bench for spi_slave_word in all four SPI modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_word;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst      = 4'hF;
    logic [3:0]  sclk     = 4'b1100;
    logic [3:0]  cs_n     = 4'hF;
    logic [3:0]  mosi     = 4'h0;
    logic [3:0]  tx_valid = 4'h0;
    logic [7:0]  txd0 = 8'h00;
    logic [7:0]  txd1 = 8'h00;
    logic [7:0]  txd2 = 8'h00;
    logic [15:0] txd3 = 16'h0000;
    wire  [3:0]  tx_ready, und, rxv, abt, busy, miso, oe;
    wire  [7:0]  rxd0, rxd1, rxd2;
    wire  [15:0] rxd3;

    spi_slave_word #(.WORD_W(8), .SPI_MODE(0), .LSB_FIRST(1'b0), .IDLE_WORD(8'h00)) u_dut0 (
        .i_Clk(clk), .i_Rst(rst[0]), .i_TX_Data(txd0), .i_TX_Valid(tx_valid[0]),
        .o_TX_Ready(tx_ready[0]), .o_TX_Underrun(und[0]), .o_RX_Data(rxd0), .o_RX_Valid(rxv[0]),
        .o_Abort(abt[0]), .o_Busy(busy[0]), .i_SPI_Clk(sclk[0]), .i_SPI_CS_n(cs_n[0]),
        .i_SPI_MOSI(mosi[0]), .o_SPI_MISO(miso[0]), .o_SPI_MISO_OE(oe[0]));
    spi_slave_word #(.WORD_W(8), .SPI_MODE(1), .LSB_FIRST(1'b0), .IDLE_WORD(8'hFF)) u_dut1 (
        .i_Clk(clk), .i_Rst(rst[1]), .i_TX_Data(txd1), .i_TX_Valid(tx_valid[1]),
        .o_TX_Ready(tx_ready[1]), .o_TX_Underrun(und[1]), .o_RX_Data(rxd1), .o_RX_Valid(rxv[1]),
        .o_Abort(abt[1]), .o_Busy(busy[1]), .i_SPI_Clk(sclk[1]), .i_SPI_CS_n(cs_n[1]),
        .i_SPI_MOSI(mosi[1]), .o_SPI_MISO(miso[1]), .o_SPI_MISO_OE(oe[1]));
    spi_slave_word #(.WORD_W(8), .SPI_MODE(2), .LSB_FIRST(1'b0), .IDLE_WORD(8'h00)) u_dut2 (
        .i_Clk(clk), .i_Rst(rst[2]), .i_TX_Data(txd2), .i_TX_Valid(tx_valid[2]),
        .o_TX_Ready(tx_ready[2]), .o_TX_Underrun(und[2]), .o_RX_Data(rxd2), .o_RX_Valid(rxv[2]),
        .o_Abort(abt[2]), .o_Busy(busy[2]), .i_SPI_Clk(sclk[2]), .i_SPI_CS_n(cs_n[2]),
        .i_SPI_MOSI(mosi[2]), .o_SPI_MISO(miso[2]), .o_SPI_MISO_OE(oe[2]));
    spi_slave_word #(.WORD_W(16), .SPI_MODE(3), .LSB_FIRST(1'b1), .IDLE_WORD(16'h0000)) u_dut3 (
        .i_Clk(clk), .i_Rst(rst[3]), .i_TX_Data(txd3), .i_TX_Valid(tx_valid[3]),
        .o_TX_Ready(tx_ready[3]), .o_TX_Underrun(und[3]), .o_RX_Data(rxd3), .o_RX_Valid(rxv[3]),
        .o_Abort(abt[3]), .o_Busy(busy[3]), .i_SPI_Clk(sclk[3]), .i_SPI_CS_n(cs_n[3]),
        .i_SPI_MOSI(mosi[3]), .o_SPI_MISO(miso[3]), .o_SPI_MISO_OE(oe[3]));

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [15:0] rx_log [4][64];
    int rx_cnt  [4] = '{default: 0};
    int und_cnt [4] = '{default: 0};
    int abt_cnt [4] = '{default: 0};
    logic [7:0] acc_q [$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] rx_of(input int d);
        case (d)
            0:       return {8'h00, rxd0};
            1:       return {8'h00, rxd1};
            2:       return {8'h00, rxd2};
            default: return rxd3;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rxv[d]) begin
                rx_log[d][rx_cnt[d] % 64] <= rx_of(d);
                rx_cnt[d] <= rx_cnt[d] + 1;
            end
            if (und[d]) und_cnt[d] <= und_cnt[d] + 1;
            if (abt[d]) abt_cnt[d] <= abt_cnt[d] + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low(input int d);
        cs_n[d] = 1'b0;
        cyc(4);
    endtask

    task automatic cs_high(input int d, input int half);
        cyc(half);
        cs_n[d] = 1'b1;
        cyc(6);
    endtask

    task automatic offer(input int d, input logic [15:0] w, input bit track);
        bit done = 1'b0;
        if (d == 3) txd3 = w;
        else        txd0 = w[7:0];
        tx_valid[d] = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (tx_ready[d]) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        tx_valid[d] = 1'b0;
        chk("tx_accept", {31'd0, done}, 32'd1);
        if (done && track) acc_q.push_back(w[7:0]);
    endtask

    // SPI master: drives one word (or nbits of it) and captures MISO at the sample edge.
    task automatic xfer(input int d, input int mode, input int w, input bit lsb,
                        input logic [15:0] dout, input int nbits, input int half,
                        output logic [15:0] din);
        logic cpol, cpha;
        int   b;
        cpol = (mode >= 2);
        cpha = (mode % 2 == 1);
        din  = '0;
        for (int i = 0; i < nbits; i++) begin
            b = lsb ? i : w - 1 - i;
            if (!cpha) begin
                mosi[d] = dout[b];
                cyc(half);
                din[b]  = miso[d];
                sclk[d] = ~cpol;
                cyc(half);
                sclk[d] = cpol;
            end else begin
                sclk[d] = ~cpol;
                mosi[d] = dout[b];
                cyc(half);
                din[b]  = miso[d];
                sclk[d] = cpol;
                cyc(half);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [5];
        logic [15:0] din, m0, m1;
        logic [7:0]  sent [10];
        logic [7:0]  mw   [10];
        int          n0, u0, a0, matched;

        tbl[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 1};
        tbl[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 1};
        tbl[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 1};
        tbl[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81, 1};
        tbl[4] = '{8'h5A, 8'hC3, 8'hC3, 8'h5A, 1};

        // Reset: every output low while reset is held, ready rises after release.
        cyc(3);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_ready%0d", d), {31'd0, tx_ready[d]}, 32'd0);
            chk($sformatf("rst_busy%0d", d),  {31'd0, busy[d]}, 32'd0);
            chk($sformatf("rst_oe%0d", d),    {31'd0, oe[d]}, 32'd0);
            chk($sformatf("rst_rxv%0d", d),   {31'd0, rxv[d]}, 32'd0);
            chk($sformatf("rst_rxd%0d", d),   {16'd0, rx_of(d)}, 32'd0);
        end
        rst = 4'h0;
        cyc(1);
        for (int d = 0; d < 4; d++)
            chk($sformatf("post_rst_ready%0d", d), {31'd0, tx_ready[d]}, 32'd1);

        // Mode 0 table.
        for (int k = 0; k < 5; k++) begin
            n0 = rx_cnt[0];
            u0 = und_cnt[0];
            offer(0, {8'h00, tbl[k].tx}, 1'b0);
            chk("t1_ready_full", {31'd0, tx_ready[0]}, 32'd0);
            cs_low(0);
            chk("t1_ready_after_load", {31'd0, tx_ready[0]}, 32'd1);
            chk("t1_busy", {31'd0, busy[0]}, 32'd1);
            xfer(0, 0, 8, 1'b0, {8'h00, tbl[k].mosi}, 8, 4, din);
            cs_high(0, 4);
            chk("t1_rx_count", rx_cnt[0] - n0, 32'd1);
            chk("t1_rx_data", {16'd0, rx_log[0][n0 % 64]}, {24'd0, tbl[k].exp_rx});
            chk("t1_miso", {16'd0, din}, {24'd0, tbl[k].exp_miso});
            chk("t1_underrun", und_cnt[0] - u0, tbl[k].exp_und);
            chk("t1_idle_busy", {31'd0, busy[0]}, 32'd0);
        end

        // Mode 3, 16-bit LSB-first, second TX word offered during word 1.
        n0 = rx_cnt[3];
        u0 = und_cnt[3];
        a0 = abt_cnt[3];
        offer(3, 16'h1234, 1'b0);
        cs_low(3);
        fork
            begin
                xfer(3, 3, 16, 1'b1, 16'hCAFE, 16, 4, din);
                m0 = din;
                xfer(3, 3, 16, 1'b1, 16'h0001, 16, 4, din);
                m1 = din;
            end
            begin
                cyc(20);
                offer(3, 16'hBEEF, 1'b0);
            end
        join
        cs_high(3, 4);
        chk("t2_rx_count", rx_cnt[3] - n0, 32'd2);
        chk("t2_rx0", {16'd0, rx_log[3][n0 % 64]}, 32'h0000CAFE);
        chk("t2_rx1", {16'd0, rx_log[3][(n0 + 1) % 64]}, 32'h00000001);
        chk("t2_miso0", {16'd0, m0}, 32'h00001234);
        chk("t2_miso1", {16'd0, m1}, 32'h0000BEEF);
        chk("t2_underrun", und_cnt[3] - u0, 32'd0);
        chk("t2_abort", abt_cnt[3] - a0, 32'd0);

        // Mode 1, nothing offered: idle word streams out, one underrun per word.
        n0 = rx_cnt[1];
        u0 = und_cnt[1];
        cs_low(1);
        xfer(1, 1, 8, 1'b0, 16'h0012, 8, 4, din);
        m0 = din;
        xfer(1, 1, 8, 1'b0, 16'h0034, 8, 4, din);
        m1 = din;
        cs_high(1, 4);
        chk("t3_miso0", {16'd0, m0}, 32'h000000FF);
        chk("t3_miso1", {16'd0, m1}, 32'h000000FF);
        chk("t3_underrun", und_cnt[1] - u0, 32'd2);
        chk("t3_rx0", {16'd0, rx_log[1][n0 % 64]}, 32'h00000012);
        chk("t3_rx1", {16'd0, rx_log[1][(n0 + 1) % 64]}, 32'h00000034);

        // Mode 2: abort after 5 bits, then a clean word.
        n0 = rx_cnt[2];
        a0 = abt_cnt[2];
        cs_low(2);
        xfer(2, 2, 8, 1'b0, 16'h00F0, 5, 4, din);
        cs_high(2, 4);
        chk("t4_abort", abt_cnt[2] - a0, 32'd1);
        chk("t4_no_rx", rx_cnt[2] - n0, 32'd0);
        chk("t4_rxd_hold", {24'd0, rxd2}, 32'd0);
        cs_low(2);
        xfer(2, 2, 8, 1'b0, 16'h0081, 8, 4, din);
        cs_high(2, 4);
        chk("t4_rx_count", rx_cnt[2] - n0, 32'd1);
        chk("t4_rx_data", {16'd0, rx_log[2][n0 % 64]}, 32'h00000081);
        chk("t4_abort_total", abt_cnt[2] - a0, 32'd1);

        // Reset mid-word on DUT 0.
        n0 = rx_cnt[0];
        a0 = abt_cnt[0];
        cs_low(0);
        xfer(0, 0, 8, 1'b0, 16'h00E0, 3, 4, din);
        rst[0] = 1'b1;
        cyc(1);
        chk("t5_busy", {31'd0, busy[0]}, 32'd0);
        chk("t5_oe", {31'd0, oe[0]}, 32'd0);
        chk("t5_rxv", {31'd0, rxv[0]}, 32'd0);
        cs_n[0] = 1'b1;
        sclk[0] = 1'b0;
        cyc(2);
        rst[0] = 1'b0;
        cyc(1);
        chk("t5_ready", {31'd0, tx_ready[0]}, 32'd1);
        chk("t5_busy_after", {31'd0, busy[0]}, 32'd0);
        chk("t5_no_abort", abt_cnt[0] - a0, 32'd0);
        chk("t5_no_rx", rx_cnt[0] - n0, 32'd0);
        offer(0, 16'h0066, 1'b0);
        cs_low(0);
        xfer(0, 0, 8, 1'b0, 16'h0055, 8, 4, din);
        cs_high(0, 4);
        chk("t5_rx_count", rx_cnt[0] - n0, 32'd1);
        chk("t5_rx_data", {16'd0, rx_log[0][n0 % 64]}, 32'h00000055);
        chk("t5_miso", {16'd0, din}, 32'h00000066);

        // Minimum half-period with randomly timed TX offers.
        acc_q.delete();
        matched = 0;
        n0 = rx_cnt[0];
        cs_low(0);
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    sent[k] = 8'($urandom_range(1, 255));
                    xfer(0, 0, 8, 1'b0, {8'h00, sent[k]}, 8, 3, din);
                    mw[k] = din[7:0];
                end
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    cyc($urandom_range(0, 20));
                    offer(0, 16'($urandom_range(1, 255)), 1'b1);
                end
            end
        join
        cs_high(0, 3);
        chk("t6_rx_count", rx_cnt[0] - n0, 32'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("t6_rx%0d", k), {16'd0, rx_log[0][(n0 + k) % 64]}, {24'd0, sent[k]});
        for (int k = 0; k < 10; k++) begin
            if (mw[k] != 8'h00) begin
                if (acc_q.size() == 0) begin
                    chk($sformatf("t6_miso_extra%0d", k), {24'd0, mw[k]}, 32'd0);
                end else begin
                    chk($sformatf("t6_miso%0d", k), {24'd0, mw[k]}, {24'd0, acc_q.pop_front()});
                    matched++;
                end
            end
        end
        chk("t6_matched_any", {31'd0, matched > 0}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
